// File: rtl/gs_butterfly.sv
// Three-stage Gentleman-Sande butterfly for Kyber (q = 3329):
// u' = (u + v) mod q, v' = ((u - v) mod q) * w mod q, with a valid/ready handshake on both sides.
module gs_butterfly #(
  parameter int Q      = 3329,
  parameter int W      = 12,
  parameter int BARR_M = 5039
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_u,
  input  logic [W-1:0] in_v,
  input  logic [W-1:0] in_w,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_u,
  output logic [W-1:0] out_v
);

  localparam int W1 = W + 1;
  localparam int PW = 2 * W;
  localparam int XW = PW + W + 1;

  localparam logic [W1-1:0] Q_S = W1'(Q);
  localparam logic [W-1:0]  Q_W = W'(Q);
  localparam logic [XW-1:0] Q_X = XW'(Q);
  localparam logic [XW-1:0] M_X = XW'(BARR_M);

  logic          adv;
  logic [W1-1:0] s_sum;
  logic [W1-1:0] s_dif;
  logic [W-1:0]  su;
  logic [W-1:0]  sd;

  logic [W-1:0]  su1;
  logic [W-1:0]  sd1;
  logic [W-1:0]  w1;
  logic          v1;

  logic [PW-1:0] p_next;
  logic [PW-1:0] p2;
  logic [W-1:0]  su2;
  logic          v2;

  logic [XW-1:0] prod;
  logic [XW-1:0] t_est;
  logic [XW-1:0] r_full;
  logic [W-1:0]  v_red;

  // The whole pipeline moves together; any stall at the output freezes every stage.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  always_comb begin
    s_sum = {1'b0, in_u} + {1'b0, in_v};
    su    = (s_sum >= Q_S) ? W'(s_sum - Q_S) : W'(s_sum);
    s_dif = {1'b0, in_u} - {1'b0, in_v};
    sd    = s_dif[W] ? (s_dif[W-1:0] + Q_W) : s_dif[W-1:0];
  end

  assign p_next = PW'(sd1) * PW'(w1);

  // Barrett estimate undershoots by at most one multiple of Q, so a single
  // conditional subtract finishes the reduction.
  always_comb begin
    prod   = XW'(p2) * M_X;
    t_est  = prod >> PW;
    r_full = XW'(p2) - (t_est * Q_X);
    v_red  = (r_full >= Q_X) ? W'(r_full - Q_X) : W'(r_full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      su1       <= '0;
      sd1       <= '0;
      w1        <= '0;
      v1        <= 1'b0;
      p2        <= '0;
      su2       <= '0;
      v2        <= 1'b0;
      out_u     <= '0;
      out_v     <= '0;
      out_valid <= 1'b0;
    end else if (adv) begin
      su1       <= su;
      sd1       <= sd;
      w1        <= in_w;
      v1        <= in_valid & in_ready;
      p2        <= p_next;
      su2       <= su1;
      v2        <= v1;
      out_u     <= su2;
      out_v     <= v_red;
      out_valid <= v2;
    end
  end

endmodule
